// File: rtl/pc_redirect_ctrl_pkg.sv
// pc_redirect_ctrl_pkg: redirect source codes, FSM states and default widths.
package pc_redirect_ctrl_pkg;
  localparam int PC_W_DEF = 64;
  localparam logic [1:0] REDIR_SRC_NONE = 2'b00;
  localparam logic [1:0] REDIR_SRC_DEC2 = 2'b01;
  localparam logic [1:0] REDIR_SRC_DEC1 = 2'b10;
  localparam logic [1:0] REDIR_SRC_TRAP = 2'b11;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_PEND = 1'b1;
endpackage

// File: rtl/pc_redirect_ctrl_prio_sel.sv
// redir_prio_sel: fixed-priority pick of trap > decode1 > decode2.
module redir_prio_sel
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            trap_ena_i,
  input  logic [PC_W-1:0] trap_pc_i,
  input  logic            decode1_ena_i,
  input  logic [PC_W-1:0] decode1_pc_i,
  input  logic            decode2_ena_i,
  input  logic [PC_W-1:0] decode2_pc_i,
  output logic            req_v_o,
  output logic [PC_W-1:0] req_pc_o,
  output logic [1:0]      req_src_o
);
  always_comb begin
    req_v_o   = trap_ena_i | decode1_ena_i | decode2_ena_i;
    req_pc_o  = trap_ena_i ? trap_pc_i : decode1_ena_i ? decode1_pc_i :
                decode2_ena_i ? decode2_pc_i : '0;
    req_src_o = trap_ena_i ? REDIR_SRC_TRAP : decode1_ena_i ? REDIR_SRC_DEC1 :
                decode2_ena_i ? REDIR_SRC_DEC2 : REDIR_SRC_NONE;
  end
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: registers one PC redirect per cycle, buffering it while fetch is busy.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int EPOCH_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cache_un_ready,
  input  logic               trap_ena,
  input  logic [PC_W-1:0]    trap_pc,
  input  logic               decode1_ena,
  input  logic [PC_W-1:0]    decode1_pc,
  input  logic               decode2_ena,
  input  logic [PC_W-1:0]    decode2_pc,
  output logic               redir_valid,
  output logic [PC_W-1:0]    redir_pc,
  output logic [1:0]         redir_src,
  output logic [EPOCH_W-1:0] epoch,
  output logic               pend_valid,
  output logic [CNT_W-1:0]   hold_cycles
);
  logic            req_v, take_req, cand_v, issue;
  logic [PC_W-1:0] req_pc, cand_pc;
  logic [1:0]      req_src, cand_src;
  logic               pend_q, pend_d, redir_valid_q, redir_valid_d;
  logic [PC_W-1:0]    pend_pc_q, pend_pc_d, redir_pc_q, redir_pc_d;
  logic [1:0]         pend_src_q, pend_src_d, redir_src_q, redir_src_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [CNT_W-1:0]   hold_q, hold_d;

  redir_prio_sel #(.PC_W(PC_W)) u_sel (
    .trap_ena_i(trap_ena), .trap_pc_i(trap_pc),
    .decode1_ena_i(decode1_ena), .decode1_pc_i(decode1_pc),
    .decode2_ena_i(decode2_ena), .decode2_pc_i(decode2_pc),
    .req_v_o(req_v), .req_pc_o(req_pc), .req_src_o(req_src)
  );

  // A new request displaces the buffered one only if its source ranks at least as high.
  always_comb begin
    take_req      = req_v & (pend_q == ST_IDLE | req_src >= pend_src_q);
    cand_v        = req_v | pend_q;
    cand_pc       = take_req ? req_pc : pend_pc_q;
    cand_src      = take_req ? req_src : pend_src_q;
    issue         = cand_v & ~cache_un_ready;
    pend_d        = cand_v & cache_un_ready ? ST_PEND : ST_IDLE;
    pend_pc_d     = pend_d ? cand_pc : '0;
    pend_src_d    = pend_d ? cand_src : REDIR_SRC_NONE;
    redir_valid_d = issue;
    redir_pc_d    = issue ? cand_pc : '0;
    redir_src_d   = issue ? cand_src : REDIR_SRC_NONE;
    epoch_d       = issue ? epoch_q + EPOCH_W'(1) : epoch_q;
    hold_d        = pend_q & cache_un_ready & ~&hold_q ? hold_q + CNT_W'(1) : hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q        <= ST_IDLE;
      pend_pc_q     <= '0;
      pend_src_q    <= REDIR_SRC_NONE;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      redir_src_q   <= REDIR_SRC_NONE;
      epoch_q       <= '0;
      hold_q        <= '0;
    end else begin
      pend_q        <= pend_d;
      pend_pc_q     <= pend_pc_d;
      pend_src_q    <= pend_src_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      redir_src_q   <= redir_src_d;
      epoch_q       <= epoch_d;
      hold_q        <= hold_d;
    end
  end

  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign redir_src   = redir_src_q;
  assign epoch       = epoch_q;
  assign pend_valid  = pend_q;
  assign hold_cycles = hold_q;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed stimulus with a queue scoreboard checked by a redirect monitor.
module tb_pc_redirect_ctrl;
  import pc_redirect_ctrl_pkg::*;
  typedef struct packed {
    logic [63:0] pc;
    logic [1:0]  src;
    logic [2:0]  ep;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, busy = 1'b0;
  logic        t_en = 1'b0, d1_en = 1'b0, d2_en = 1'b0;
  logic [63:0] t_pc = '0, d1_pc = '0, d2_pc = '0;
  logic        redir_valid, pend_valid;
  logic [63:0] redir_pc;
  logic [1:0]  redir_src;
  logic [2:0]  epoch;
  logic [3:0]  hold_cycles;
  exp_t        exp_q[$];
  int          checks = 0, errors = 0;
  logic [2:0]  exp_ep = '0;

  pc_redirect_ctrl #(.PC_W(64), .EPOCH_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cache_un_ready(busy),
    .trap_ena(t_en), .trap_pc(t_pc),
    .decode1_ena(d1_en), .decode1_pc(d1_pc),
    .decode2_ena(d2_en), .decode2_pc(d2_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_src(redir_src),
    .epoch(epoch), .pend_valid(pend_valid), .hold_cycles(hold_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, input logic [1:0] src);
    exp_ep = exp_ep + 3'd1;
    exp_q.push_back('{pc: pc, src: src, ep: exp_ep});
  endtask

  task automatic cyc(input logic b, input logic t, input logic [63:0] tp,
                     input logic d1, input logic [63:0] d1p,
                     input logic d2, input logic [63:0] d2p);
    busy = b; t_en = t; t_pc = tp; d1_en = d1; d1_pc = d1p; d2_en = d2; d2_pc = d2p;
    @(posedge clk);
    #1;
    t_en = 1'b0; d1_en = 1'b0; d2_en = 1'b0;
  endtask

  task automatic idle(input logic b, input int n);
    for (int i = 0; i < n; i++) cyc(b, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(redir_valid), 64'd0);
    chk({tag, "_pc"}, redir_pc, 64'd0);
    chk({tag, "_src"}, 64'(redir_src), 64'd0);
    chk({tag, "_epoch"}, 64'(epoch), 64'd0);
    chk({tag, "_pend"}, 64'(pend_valid), 64'd0);
    chk({tag, "_hold"}, 64'(hold_cycles), 64'd0);
  endtask

  // Monitor: every pulse must match the oldest expected redirect; idle outputs must be zero.
  always @(negedge clk) begin
    if (redir_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got pc=0x%0h src=%0d expected no pulse", redir_pc, redir_src);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_pc", redir_pc, e.pc);
        chk("pulse_src", 64'(redir_src), 64'(e.src));
        chk("pulse_epoch", 64'(epoch), 64'(e.ep));
      end
    end else if (!rst) begin
      chk("idle_pc_src_zero", {redir_pc[61:0], redir_src}, 64'd0);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    idle(1'b0, 2);
    // 1: single decode1 redirect, latency 1
    push(64'h8000_0040, REDIR_SRC_DEC1);
    cyc(1'b0, 1'b0, '0, 1'b1, 64'h8000_0040, 1'b0, '0);
    chk("t1_valid_next", 64'(redir_valid), 64'd1);
    idle(1'b0, 2);
    // 2: all three at once, trap wins
    push(64'h8000_0100, REDIR_SRC_TRAP);
    cyc(1'b0, 1'b1, 64'h8000_0100, 1'b1, 64'h8000_0140, 1'b1, 64'h8000_0180);
    idle(1'b0, 2);
    // 3: decode2 held while busy
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 64'h8000_0200);
    idle(1'b1, 5);
    chk("t3_pend", 64'(pend_valid), 64'd1);
    chk("t3_hold", 64'(hold_cycles), 64'd5);
    push(64'h8000_0200, REDIR_SRC_DEC2);
    idle(1'b0, 1);
    chk("t3_pend_clear", 64'(pend_valid), 64'd0);
    idle(1'b0, 2);
    // 4a: pending trap survives a later decode1
    cyc(1'b1, 1'b1, 64'h8000_0300, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b1, 64'h8000_0340, 1'b0, '0);
    push(64'h8000_0300, REDIR_SRC_TRAP);
    idle(1'b0, 1);
    // 4b: later trap replaces pending decode1
    cyc(1'b1, 1'b0, '0, 1'b1, 64'h8000_0400, 1'b0, '0);
    cyc(1'b1, 1'b1, 64'h8000_0480, 1'b0, '0, 1'b0, '0);
    push(64'h8000_0480, REDIR_SRC_TRAP);
    idle(1'b0, 1);
    chk("t4_hold", 64'(hold_cycles), 64'd7);
    idle(1'b0, 2);
    // 5: nine back-to-back issues wrap the epoch; odd PCs pass unmasked
    rst = 1'b1;
    idle(1'b0, 1);
    rst = 1'b0;
    exp_ep = '0;
    chk("t5_epoch_reset", 64'(epoch), 64'd0);
    for (int i = 0; i < 9; i++) begin
      push(64'hFFFF_0000_0000_1001 + 64'(i) * 64'h8, REDIR_SRC_DEC2);
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 64'hFFFF_0000_0000_1001 + 64'(i) * 64'h8);
    end
    idle(1'b0, 2);
    chk("t5_epoch_final", 64'(epoch), 64'd1);
    // hold counter saturation
    cyc(1'b1, 1'b0, '0, 1'b1, 64'h8000_0500, 1'b0, '0);
    idle(1'b1, 20);
    chk("t5_hold_sat", 64'(hold_cycles), 64'd15);
    chk("t5_pend", 64'(pend_valid), 64'd1);
    // 6: reset discards the pending redirect
    rst = 1'b1;
    idle(1'b1, 1);
    chk_all_zero("t6");
    rst = 1'b0;
    exp_ep = '0;
    idle(1'b0, 4);
    chk("t6_pend_after", 64'(pend_valid), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
